// File: rtl/cve2_ex_ctrl.sv
// -----------------------------------------------------------------------------
// cve2_ex_ctrl
//
// EX-stage sequencing controller between the ID stage and cve2_ex_block.
// Accepts one instruction at a time, drives the ALU / multiplier / divider
// enables and selects, owns the two 34-bit intermediate-value (imd)
// registers, detects completion through ex_valid_i, and buffers the result
// in a one-entry writeback register. A watchdog aborts multi-cycle
// operations that never complete.
//
// Parameters
//   MdEnable      : 1 = multiplier/divider present; 0 = MUL/DIV run as ALU ops
//   TimeoutCycles : maximum EXEC cycles before abort (legal range 2..64)
//
// Ports
//   clk_i, rst_i              : clock, synchronous active-high reset
//   issue_valid_i/type_i      : instruction offer from ID (00 ALU, 01 MUL,
//                               10 DIV, 11 reserved -> ALU)
//   issue_ready_o             : instruction accepted this cycle
//   flush_i                   : kill the in-flight instruction
//   mult_en_o, div_en_o       : dynamic enables to the multdiv unit
//   mult_sel_o, div_sel_o     : static data-mux selects
//   alu_instr_first_cycle_o   : first EXEC cycle of the instruction
//   ex_valid_i, result_ex_i   : EX block completion and result
//   imd_val_we_i/d_i/q_o      : intermediate-value register write port / contents
//   wb_valid_o/result_o       : writeback buffer, handed off on wb_ready_i
//   busy_o                    : controller not idle
//   timeout_o                 : last instruction was aborted by the watchdog
//   cycle_cnt_o               : EXEC cycles spent on current / last instruction
//   dbg_state_o               : FSM state (00 IDLE, 01 EXEC, 10 HOLD)
//
// Handshakes: an instruction transfers on a rising edge where issue_valid_i
// and issue_ready_o are both 1; a result transfers on a rising edge where
// wb_valid_o and wb_ready_i are both 1. A valid holder keeps its payload
// stable until the transfer edge; ready may change freely.
// -----------------------------------------------------------------------------
module cve2_ex_ctrl #(
   parameter bit          MdEnable      = 1'b1,
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             issue_valid_i,
   input  logic [1:0]       issue_type_i,
   output logic             issue_ready_o,
   input  logic             flush_i,

   output logic             mult_en_o,
   output logic             div_en_o,
   output logic             mult_sel_o,
   output logic             div_sel_o,
   output logic             alu_instr_first_cycle_o,

   input  logic             ex_valid_i,
   input  logic [31:0]      result_ex_i,

   input  logic [1:0]       imd_val_we_i,
   input  logic [1:0][33:0] imd_val_d_i,
   output logic [1:0][33:0] imd_val_q_o,

   output logic             wb_valid_o,
   output logic [31:0]      wb_result_o,
   input  logic             wb_ready_i,

   output logic             busy_o,
   output logic             timeout_o,
   output logic [5:0]       cycle_cnt_o,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   localparam logic [1:0] TYPE_MUL = 2'b01;
   localparam logic [1:0] TYPE_DIV = 2'b10;

   // Counter value seen during the last permitted EXEC cycle.
   localparam logic [5:0] CNT_LAST = 6'(TimeoutCycles - 1);
   localparam logic [5:0] CNT_MAX  = 6'd63;

   state_e           state_q;
   logic [1:0]       type_q;
   logic [5:0]       cnt_q;
   logic [31:0]      wb_result_q;
   logic             timeout_q;
   logic [1:0][33:0] imd_q;

   logic             accept;
   logic             is_mul;
   logic             is_div;

   // Ready in IDLE, or in HOLD when the buffered result leaves this cycle.
   // Flush wins over any new issue.
   assign issue_ready_o = ~flush_i &
                          ((state_q == S_IDLE) | ((state_q == S_HOLD) & wb_ready_i));
   assign accept        = issue_ready_o & issue_valid_i;

   // Without a multdiv unit the MUL/DIV types fall back to plain ALU handling.
   assign is_mul = MdEnable & (type_q == TYPE_MUL);
   assign is_div = MdEnable & (type_q == TYPE_DIV);

   assign mult_sel_o              = (state_q == S_EXEC) & is_mul;
   assign div_sel_o               = (state_q == S_EXEC) & is_div;
   assign mult_en_o               = mult_sel_o;
   assign div_en_o                = div_sel_o;
   assign alu_instr_first_cycle_o = (state_q == S_EXEC) & (cnt_q == 6'd0);

   assign wb_valid_o  = (state_q == S_HOLD);
   assign wb_result_o = wb_result_q;
   assign imd_val_q_o = imd_q;
   assign busy_o      = (state_q != S_IDLE);
   assign timeout_o   = timeout_q;
   assign cycle_cnt_o = cnt_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         type_q      <= 2'b00;
         cnt_q       <= 6'd0;
         wb_result_q <= 32'd0;
         timeout_q   <= 1'b0;
         imd_q       <= '0;
      end else if (flush_i) begin
         // Drop the instruction and any buffered result; the watchdog flag
         // still describes the last completed instruction, so it is kept.
         state_q <= S_IDLE;
         imd_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // Leaving IDLE is handled by the accept block below.
            end

            S_EXEC: begin
               if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 6'd1;
               end
               for (int i = 0; i < 2; i++) begin
                  if (imd_val_we_i[i]) begin
                     imd_q[i] <= imd_val_d_i[i];
                  end
               end
               if (ex_valid_i) begin
                  wb_result_q <= result_ex_i;
                  state_q     <= S_HOLD;
               end else if (cnt_q == CNT_LAST) begin
                  // Watchdog abort: hand back a zero result flagged by timeout_o.
                  wb_result_q <= 32'd0;
                  timeout_q   <= 1'b1;
                  state_q     <= S_HOLD;
               end
            end

            S_HOLD: begin
               if (wb_ready_i && !issue_valid_i) begin
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase

         // A new instruction starts clean. Placed last so the clear takes
         // priority over any imd write or state change above.
         if (accept) begin
            type_q    <= issue_type_i;
            cnt_q     <= 6'd0;
            timeout_q <= 1'b0;
            imd_q     <= '0;
            state_q   <= S_EXEC;
         end
      end
   end

endmodule
